// File: rtl/eth_payload_serializer.sv
// eth_payload_serializer: buffers one payload, pulses tx_start, waits the header time, streams N-bit chunks MSB-first with zero padding and an IFG.
module eth_payload_serializer #(
   parameter int N          = 2,
   parameter int MAX_BYTES  = 1500,
   parameter int MIN_BYTES  = 46,
   parameter int HDR_CYCLES = 88,
   parameter int IFG_CYCLES = 48
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   byte_in,
   input  logic         byte_valid,
   input  logic         byte_last,
   output logic         byte_ready,
   output logic         tx_start,
   output logic         axiov,
   output logic [N-1:0] axiod,
   output logic         overflow,
   output logic         busy
);
   localparam int S    = $clog2(8 / N);
   localparam int LMAX = MAX_BYTES > MIN_BYTES ? MAX_BYTES : MIN_BYTES;
   localparam int CW   = $clog2(LMAX * 8 / N + 1);
   localparam int AW   = $clog2(MAX_BYTES);
   localparam int TMAX = HDR_CYCLES > IFG_CYCLES ? HDR_CYCLES : IFG_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {FILL, START, HOLD, SEND, GAP} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, tot_q, tot_d, pos_q, pos_d;
   logic [CW-1:0]  idx_q, idx_d, lb;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic           ovf_q, ovf_d, rdy_q, rdy_d;
   logic           we, acc, fin;
   logic [AW-1:0]  ra;
   logic [2:0]     msb;
   logic [7:0]     mem [MAX_BYTES];
   logic [7:0]     rd_q;

   assign acc   = byte_valid & rdy_q;
   assign idx_q = pos_q >> S;
   assign idx_d = pos_d >> S;
   assign lb    = cnt_q > CW'(MIN_BYTES) ? cnt_q : CW'(MIN_BYTES);
   assign fin   = pos_q == tot_q - 1'b1;
   assign rdy_d = state_d == FILL;
   // Reading at the next index keeps rd_q aligned with the byte being shifted out.
   assign ra    = idx_d < CW'(MAX_BYTES) ? idx_d[AW-1:0] : '0;
   assign msb   = 3'(7 - N * int'(pos_q[S-1:0]));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      tot_d   = tot_q;
      pos_d   = pos_q;
      tmr_d   = tmr_q;
      we      = 1'b0;
      case (state_q)
         FILL: if (acc) begin
            we      = cnt_q != CW'(MAX_BYTES);
            cnt_d   = we ? cnt_q + 1'b1 : cnt_q;
            ovf_d   = ovf_q | ~we;
            state_d = byte_last ? START : FILL;
         end
         START: begin
            tot_d   = lb << S;
            pos_d   = '0;
            tmr_d   = '0;
            state_d = HOLD;
         end
         HOLD: begin
            tmr_d   = tmr_q + 1'b1;
            state_d = tmr_q == TW'(HDR_CYCLES - 1) ? SEND : HOLD;
         end
         SEND: begin
            pos_d   = pos_q + 1'b1;
            tmr_d   = '0;
            state_d = fin ? GAP : SEND;
         end
         GAP: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TW'(IFG_CYCLES - 1)) begin
               state_d = FILL;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
         tot_q   <= '0;
         pos_q   <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rdy_q   <= rdy_d;
         tot_q   <= tot_d;
         pos_q   <= pos_d;
         tmr_q   <= tmr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[cnt_q[AW-1:0]] <= byte_in;
      rd_q <= mem[ra];
   end

   assign byte_ready = rdy_q;
   assign tx_start   = state_q == START;
   assign axiov      = state_q == SEND;
   assign busy       = state_q != FILL;
   assign overflow   = ovf_q;
   assign axiod      = (state_q == SEND && idx_q < cnt_q) ? rd_q[msb -: N] : '0;
endmodule
